// File: rtl/ara_pkg.sv
// Shared slide-unit types and sizing helpers.
package ara_pkg;

  // Per-request emission order of the stride components.
  typedef enum logic {
    P2_LSB_FIRST = 1'b0,
    P2_MSB_FIRST = 1'b1
  } p2_order_e;

  // Bits needed to index num_idx items, never less than one.
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 1) ? unsigned'($clog2(num_idx)) : 1;
  endfunction

  // Stride width of the slide unit: a byte offset across all lanes.
  function automatic int unsigned sldu_stride_width(input int unsigned nr_lanes);
    return idx_width(8 * nr_lanes);
  endfunction

endpackage

// File: rtl/p2_onehot_sel.sv
// Picks the lowest or highest set bit of a vector as a one-hot value.
module p2_onehot_sel #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] data_i,
  input  logic             msb_first_i,
  output logic [Width-1:0] onehot_o,
  output logic             empty_o
);

  logic [Width-1:0] lsb_hot;
  logic [Width-1:0] msb_hot;

  // Two's-complement trick isolates the lowest set bit.
  assign lsb_hot = data_i & (~data_i + Width'(1));

  // Scan upward so the highest set bit is the one left standing.
  always_comb begin
    msb_hot = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      if (data_i[i]) begin
        msb_hot    = '0;
        msb_hot[i] = 1'b1;
      end
    end
  end

  assign onehot_o = msb_first_i ? msb_hot : lsb_hot;
  assign empty_o  = ~|data_i;

endmodule

// File: rtl/popcount.sv
// Population count of a bit vector (common_cells-compatible interface).
module popcount #(
  parameter int unsigned INPUT_WIDTH = 256
) (
  input  logic [INPUT_WIDTH-1:0]     data_i,
  output logic [$clog2(INPUT_WIDTH):0] popcount_o
);

  localparam int unsigned CntW = $clog2(INPUT_WIDTH) + 1;

  // Plain adder chain; widths here are small enough that a tree buys nothing.
  always_comb begin
    popcount_o = '0;
    for (int unsigned i = 0; i < INPUT_WIDTH; i++) begin
      popcount_o = popcount_o + CntW'(data_i[i]);
    end
  end

endmodule

// File: rtl/p2_stride_seq.sv
// Power-of-two stride sequencer: splits a stride into its one-hot
// components and emits them one per valid/ready beat, LSB- or MSB-first.
// Optional running offset output acc_o is enabled by P2_STRIDE_SEQ_ACC_EN.
module p2_stride_seq
  import ara_pkg::*;
#(
  parameter int unsigned NrLanes     = 0,
  parameter int unsigned StrideWidth = sldu_stride_width(NrLanes),
  parameter int unsigned PopcWidth   = idx_width(StrideWidth) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [StrideWidth-1:0] stride_i,
  input  logic                   msb_first_i,
  input  logic                   stride_valid_i,
  output logic                   stride_ready_o,
  output logic [StrideWidth-1:0] stride_p2_o,
  output logic [PopcWidth-1:0]   popc_o,
  output logic                   last_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   done_o
`ifdef P2_STRIDE_SEQ_ACC_EN
  ,
  output logic [StrideWidth-1:0] acc_o
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int unsigned CntW = $clog2(StrideWidth) + 1;

  logic [0:0]             state_q;
  logic [StrideWidth-1:0] residual_q;
  logic                   msb_first_q;
  logic                   done_q;

  logic [StrideWidth-1:0] sel_p2;
  logic                   residual_empty;
  logic [CntW-1:0]        residual_cnt;
  logic                   out_hs;
  logic                   accept;
  logic                   stride_nz;

  p2_onehot_sel #(
    .Width (StrideWidth)
  ) u_sel (
    .data_i      (residual_q),
    .msb_first_i (msb_first_q == P2_MSB_FIRST),
    .onehot_o    (sel_p2),
    .empty_o     (residual_empty)
  );

  popcount #(
    .INPUT_WIDTH (StrideWidth)
  ) u_popc (
    .data_i     (residual_q),
    .popcount_o (residual_cnt)
  );

  // RUN always holds a non-empty residual; the empty gate only keeps the
  // output quiet should that invariant ever be violated.
  assign valid_o     = (state_q == RUN) & ~residual_empty;
  assign stride_p2_o = valid_o ? sel_p2 : '0;
  assign popc_o      = PopcWidth'(residual_cnt);
  assign last_o      = valid_o & (popc_o == PopcWidth'(1));
  assign done_o      = done_q;

  assign out_hs    = valid_o & ready_i;
  assign stride_nz = |stride_i;

  // A new stride may enter when idle or on the final beat of the current one,
  // which is what makes back-to-back strides gapless.
  assign stride_ready_o = ~flush_i & ((state_q == IDLE) | (out_hs & last_o));
  assign accept         = stride_valid_i & stride_ready_o;

  // Sequencer state: load on accept, peel one component per output beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      residual_q  <= '0;
      msb_first_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (flush_i) begin
      state_q    <= IDLE;
      residual_q <= '0;
      done_q     <= 1'b0;
    end else begin
      // A zero stride has nothing to emit, so it completes immediately.
      done_q <= (out_hs & last_o) | (accept & ~stride_nz);
      if (accept && stride_nz) begin
        residual_q  <= stride_i;
        msb_first_q <= msb_first_i;
        state_q     <= RUN;
      end else if (out_hs) begin
        residual_q <= residual_q ^ stride_p2_o;
        if (last_o) state_q <= IDLE;
      end
    end
  end

`ifdef P2_STRIDE_SEQ_ACC_EN
  logic [StrideWidth-1:0] acc_q;

  // Running byte offset: the sum of components is bounded by the stride,
  // so this never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      acc_q <= '0;
    end else if (accept && stride_nz) begin
      acc_q <= '0;
    end else if (out_hs) begin
      acc_q <= acc_q + stride_p2_o;
    end
  end

  assign acc_o = acc_q;
`else
  // No accumulator: beats carry no running offset.
`endif

endmodule

// File: tb/tb_p2_stride_seq.sv
// Scoreboard bench for p2_stride_seq (NrLanes = 4, StrideWidth = 5).
module tb_p2_stride_seq;

  localparam int unsigned SW = 5;
  localparam int unsigned PW = 4;

  logic          clk = 1'b0;
  logic          rst_i, flush_i, msb_first_i, stride_valid_i, ready_i;
  logic [SW-1:0] stride_i;
  logic          stride_ready_o, last_o, valid_o, done_o;
  logic [SW-1:0] stride_p2_o;
  logic [PW-1:0] popc_o;
`ifdef P2_STRIDE_SEQ_ACC_EN
  logic [SW-1:0] acc_o;
`endif

  p2_stride_seq #(.NrLanes(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .stride_i       (stride_i),
    .msb_first_i    (msb_first_i),
    .stride_valid_i (stride_valid_i),
    .stride_ready_o (stride_ready_o),
    .stride_p2_o    (stride_p2_o),
    .popc_o         (popc_o),
    .last_o         (last_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .done_o         (done_o)
`ifdef P2_STRIDE_SEQ_ACC_EN
    ,
    .acc_o          (acc_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] p2;
    logic [PW-1:0] popc;
    logic          last;
    logic [SW-1:0] acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic          pend_done = 1'b0;
  logic          prev_hold = 1'b0;
  logic [SW-1:0] prev_p2;
  logic [PW-1:0] prev_popc;

  logic rnd_en     = 1'b0;
  logic ready_dir  = 1'b1;
  logic flush_dir  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: list the set bits of the stride in the requested order.
  task automatic push_stride(input logic [SW-1:0] s, input logic m);
    int bits[$];
    int k;
    int sum;
    exp_t e;
    for (int b = 0; b < SW; b++) if (s[b]) bits.push_back(b);
    if (m) bits.reverse();
    k   = bits.size();
    sum = 0;
    for (int i = 0; i < k; i++) begin
      e.p2   = SW'(1 << bits[i]);
      e.popc = PW'(k - i);
      e.last = (i == k - 1);
      e.acc  = SW'(sum);
      sum   += (1 << bits[i]);
      q.push_back(e);
    end
  endtask

  // Drive backpressure and flush: directed values, or random when enabled.
  always @(posedge clk) begin
    #2;
    ready_i = rnd_en ? ($urandom_range(0, 3) != 0) : ready_dir;
    flush_i = flush_dir | (rnd_en && ($urandom_range(0, 39) == 0));
  end

  // Monitor: compare every cycle against the scoreboard, away from the edge.
  always @(negedge clk) begin
    exp_t e;
    logic exp_v, exp_r, new_pend;
    if (rst_i) begin
      q.delete();
      pend_done = 1'b0;
      prev_hold = 1'b0;
    end else begin
      chk("done", done_o, pend_done);
      exp_v = (q.size() != 0);
      chk("valid", valid_o, exp_v);
      exp_r = !flush_i && (q.size() == 0 || (ready_i && q.size() == 1));
      chk("stride_ready", stride_ready_o, exp_r);
      if (prev_hold) begin
        chk("hold_p2", stride_p2_o, prev_p2);
        chk("hold_popc", popc_o, prev_popc);
      end
      if (!exp_v) begin
        chk("idle_p2", stride_p2_o, 0);
        chk("idle_popc", popc_o, 0);
        chk("idle_last", last_o, 0);
      end
      new_pend = 1'b0;
      if (flush_i) begin
        q.delete();
      end else begin
        if (valid_o && ready_i && q.size() > 0) begin
          e = q.pop_front();
          chk("p2", stride_p2_o, e.p2);
          chk("popc", popc_o, e.popc);
          chk("last", last_o, e.last);
`ifdef P2_STRIDE_SEQ_ACC_EN
          chk("acc", acc_o, e.acc);
`endif
          if (q.size() == 0) new_pend = 1'b1;
        end
        if (stride_valid_i && stride_ready_o) begin
          if (stride_i == 0) new_pend = 1'b1;
          else push_stride(stride_i, msb_first_i);
        end
      end
      pend_done = new_pend;
      prev_hold = valid_o && !ready_i && !flush_i;
      prev_p2   = stride_p2_o;
      prev_popc = popc_o;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [SW-1:0] s, input logic m, input logic hold);
    int n;
    stride_i       = s;
    msb_first_i    = m;
    stride_valid_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!stride_ready_o && n < 200);
    if (n >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout at %0t: got no ready expected ready within 200 cycles", $time);
    end
    @(posedge clk); #1;
    if (!hold) stride_valid_i = 1'b0;
  endtask

  initial begin
    int n;
    rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b1;
    stride_i = '0; msb_first_i = 1'b0; stride_valid_i = 1'b0;
    idle(3);
    rst_i = 1'b0;
    idle(2);

    // 5'b01011 in both orders.
    send(5'b01011, 1'b0, 1'b0); idle(5);
    send(5'b01011, 1'b1, 1'b0); idle(5);

    // Backpressure for three cycles on the second component.
    send(5'b01011, 1'b0, 1'b0);
    @(posedge clk); #1; ready_dir = 1'b0;
    idle(3);
    ready_dir = 1'b1;
    idle(5);

    // Back-to-back strides with valid held high.
    send(5'd6, 1'b0, 1'b1);
    send(5'd1, 1'b0, 1'b0);
    idle(5);

    // Zero stride.
    send(5'd0, 1'b0, 1'b0); idle(4);

    // Flush during the second component, then a fresh stride.
    send(5'd7, 1'b0, 1'b0);
    @(posedge clk); #1; flush_dir = 1'b1;
    @(posedge clk); #1; flush_dir = 1'b0;
    send(5'd4, 1'b0, 1'b0); idle(4);

    // Reset during the second component, then a fresh stride.
    send(5'd7, 1'b0, 1'b0);
    @(posedge clk); #1; rst_i = 1'b1;
    @(posedge clk); #1; rst_i = 1'b0;
    send(5'd4, 1'b0, 1'b0); idle(4);

    // Random strides, order, back-to-back, backpressure and flushes.
    rnd_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic h;
      h = ($urandom_range(0, 2) == 0);
      send(SW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), h);
      if (!h) idle($urandom_range(0, 2));
    end
    stride_valid_i = 1'b0;
    rnd_en = 1'b0;
    ready_dir = 1'b1;

    n = 0;
    while (q.size() != 0 && n < 100) begin idle(1); n++; end
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", q.size());
    end
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
